// File: rtl/ex_mem_pipe_pkg.sv
// ex_mem_pipe_pkg: shared constants for the EX/MEM pipeline register.
//   RST_ENABLE / RST_DISABLE : active-low reset levels
//   STOP / NO_STOP           : stall request levels
//   NOP_REG_ADDR, ZERO_WORD  : values driven into an empty (bubble) slot
package ex_mem_pipe_pkg;

  localparam logic RST_ENABLE  = 1'b0;
  localparam logic RST_DISABLE = 1'b1;
  localparam logic STOP        = 1'b1;
  localparam logic NO_STOP     = 1'b0;

  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
  localparam logic [31:0] ZERO_WORD    = 32'd0;

endpackage

// File: rtl/ex_mem_pipe_stage_reg.sv
// stage_reg: generic W-bit pipeline register with priority
//   reset > clear > hold > load.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active low (q <= 0)
//   clr  : synchronous clear (q <= 0)
//   hold : keep current q
//   d    : next value on a load edge
//   q    : registered output
module stage_reg
  import ex_mem_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) q <= '0;
    else if (clr)          q <= '0;
    else if (!hold)        q <= d;
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register with stall/bubble/flush control and
// a feedback path holding multi-cycle EX state (accumulator, step count).
// Ports:
//   clk, rst (sync, active low)
//   stall_ex, stall_mem, flush        : stall controller
//   ex_*                              : EX stage results
//   mem_*                             : registered copies to MEM
//   mem_valid                         : slot holds a real instruction
//   acc_fb, cnt_fb                    : held multi-cycle state back to EX
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ACC_W  = 64,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_ex,
  input  logic              stall_mem,
  input  logic              flush,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic              ex_reg_we,
  input  logic [DATA_W-1:0] ex_alu_res,
  input  logic              ex_hi_we,
  input  logic              ex_lo_we,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  input  logic [ACC_W-1:0]  ex_acc,
  input  logic [CNT_W-1:0]  ex_cnt,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_reg_we,
  output logic [DATA_W-1:0] mem_alu_res,
  output logic              mem_hi_we,
  output logic              mem_lo_we,
  output logic [DATA_W-1:0] mem_hi,
  output logic [DATA_W-1:0] mem_lo,
  output logic              mem_valid,
  output logic [ACC_W-1:0]  acc_fb,
  output logic [CNT_W-1:0]  cnt_fb
);

  // Pipeline bundle: valid bit rides with the payload so a clear
  // simultaneously empties the slot and drops every write enable.
  localparam int PIPE_W = ADDR_W + 3*DATA_W + 4;
  localparam int FB_W   = ACC_W + CNT_W;

  logic              pipe_clr, pipe_hold;
  logic              fb_clr;
  logic [PIPE_W-1:0] pipe_d, pipe_q;
  logic [FB_W-1:0]   fb_d, fb_q;

  // Pipeline: flush or a bubble (EX stalled, MEM moving) empties the slot;
  // a double stall freezes it; otherwise load.
  assign pipe_clr  = flush | ((stall_ex == STOP) & (stall_mem == NO_STOP));
  assign pipe_hold = (stall_ex == STOP) & (stall_mem == STOP);

  // Feedback: captured on every stalled edge, cleared on flush or whenever
  // EX advances, so the next multi-cycle op starts from step 0.
  assign fb_clr = flush | (stall_ex == NO_STOP);

  assign pipe_d = {1'b1, ex_waddr, ex_reg_we, ex_alu_res,
                   ex_hi_we, ex_lo_we, ex_hi, ex_lo};
  assign fb_d   = {ex_acc, ex_cnt};

  stage_reg #(.W(PIPE_W)) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .clr  (pipe_clr),
    .hold (pipe_hold),
    .d    (pipe_d),
    .q    (pipe_q)
  );

  stage_reg #(.W(FB_W)) u_fb (
    .clk  (clk),
    .rst  (rst),
    .clr  (fb_clr),
    .hold (1'b0),
    .d    (fb_d),
    .q    (fb_q)
  );

  assign {mem_valid, mem_waddr, mem_reg_we, mem_alu_res,
          mem_hi_we, mem_lo_we, mem_hi, mem_lo} = pipe_q;
  assign {acc_fb, cnt_fb} = fb_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: directed self-checking bench for ex_mem_pipe.
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst, stall_ex, stall_mem, flush;
  logic [4:0]  ex_waddr;
  logic        ex_reg_we, ex_hi_we, ex_lo_we;
  logic [31:0] ex_alu_res, ex_hi, ex_lo;
  logic [63:0] ex_acc;
  logic [1:0]  ex_cnt;
  logic [4:0]  mem_waddr;
  logic        mem_reg_we, mem_hi_we, mem_lo_we, mem_valid;
  logic [31:0] mem_alu_res, mem_hi, mem_lo;
  logic [63:0] acc_fb;
  logic [1:0]  cnt_fb;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush(flush), .ex_waddr(ex_waddr), .ex_reg_we(ex_reg_we),
    .ex_alu_res(ex_alu_res), .ex_hi_we(ex_hi_we), .ex_lo_we(ex_lo_we),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_acc(ex_acc), .ex_cnt(ex_cnt),
    .mem_waddr(mem_waddr), .mem_reg_we(mem_reg_we),
    .mem_alu_res(mem_alu_res), .mem_hi_we(mem_hi_we),
    .mem_lo_we(mem_lo_we), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_valid(mem_valid), .acc_fb(acc_fb), .cnt_fb(cnt_fb)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; the controller must never request the illegal combo.
  task automatic tick();
    ntests++;
    assert (!(rst && !stall_ex && stall_mem)) else begin
      nfail++;
      $error("FAIL illegal_stall observed=%0b%0b expected=not 01",
             stall_ex, stall_mem);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 64'(mem_valid), 64'd0);
    chk({tag, "_we"}, {61'd0, mem_reg_we, mem_hi_we, mem_lo_we}, 64'd0);
    chk({tag, "_waddr"}, 64'(mem_waddr), 64'd0);
    chk({tag, "_alu"}, 64'(mem_alu_res), 64'd0);
  endtask

  initial begin
    rst = 0; stall_ex = 0; stall_mem = 0; flush = 0;
    ex_waddr = 5'd3; ex_reg_we = 1; ex_alu_res = 32'hDEADBEEF;
    ex_hi_we = 1; ex_lo_we = 1; ex_hi = 32'h1111; ex_lo = 32'h2222;
    ex_acc = 64'hFFFF; ex_cnt = 2'd3;

    // Reset held for two edges
    tick();
    chk_empty("rst1");
    chk("rst1_hi", 64'(mem_hi), 64'd0);
    chk("rst1_acc", acc_fb, 64'd0);
    chk("rst1_cnt", 64'(cnt_fb), 64'd0);
    tick();
    chk_empty("rst2");

    // Plain load
    rst = 1; ex_waddr = 5'd5; ex_alu_res = 32'h12345678; ex_reg_we = 1;
    ex_hi_we = 1; ex_lo_we = 0; ex_hi = 32'hCAFEF00D; ex_lo = 32'h0;
    tick();
    chk("ld_waddr", 64'(mem_waddr), 64'd5);
    chk("ld_alu", 64'(mem_alu_res), 64'h12345678);
    chk("ld_valid", 64'(mem_valid), 64'd1);
    chk("ld_we", {61'd0, mem_reg_we, mem_hi_we, mem_lo_we}, 64'b110);
    chk("ld_hi", 64'(mem_hi), 64'hCAFEF00D);
    chk("ld_acc", acc_fb, 64'd0);

    // Bubble: EX stalled, MEM advancing
    stall_ex = 1; ex_acc = 64'h1_0000_0002; ex_cnt = 2'd1; ex_reg_we = 1;
    ex_alu_res = 32'h99999999;
    tick();
    chk_empty("bub");
    chk("bub_acc", acc_fb, 64'h1_0000_0002);
    chk("bub_cnt", 64'(cnt_fb), 64'd1);
    stall_ex = 0; ex_cnt = 2'd2; ex_waddr = 5'd7; ex_alu_res = 32'h11112222;
    tick();
    chk("rel_valid", 64'(mem_valid), 64'd1);
    chk("rel_alu", 64'(mem_alu_res), 64'h11112222);
    chk("rel_waddr", 64'(mem_waddr), 64'd7);
    chk("rel_acc", acc_fb, 64'd0);
    chk("rel_cnt", 64'(cnt_fb), 64'd0);

    // Double stall holds the slot while feedback tracks EX
    ex_waddr = 5'd9; ex_alu_res = 32'hAAAA5555; ex_reg_we = 1;
    tick();
    chk("ds_ld_alu", 64'(mem_alu_res), 64'hAAAA5555);
    stall_ex = 1; stall_mem = 1;
    for (int i = 1; i <= 3; i++) begin
      ex_alu_res = 32'(i); ex_waddr = 5'(i + 20);
      ex_acc = 64'(i * 256 + 3); ex_cnt = 2'(i);
      tick();
      chk($sformatf("ds%0d_alu", i), 64'(mem_alu_res), 64'hAAAA5555);
      chk($sformatf("ds%0d_waddr", i), 64'(mem_waddr), 64'd9);
      chk($sformatf("ds%0d_valid", i), 64'(mem_valid), 64'd1);
      chk($sformatf("ds%0d_acc", i), acc_fb, 64'(i * 256 + 3));
      chk($sformatf("ds%0d_cnt", i), 64'(cnt_fb), 64'(i));
    end

    // Flush wins over a double stall
    flush = 1;
    tick();
    chk_empty("fl");
    chk("fl_acc", acc_fb, 64'd0);
    chk("fl_cnt", 64'(cnt_fb), 64'd0);

    // Mid-op reset during a madd stall
    flush = 0; stall_ex = 0; stall_mem = 0;
    ex_waddr = 5'd4; ex_alu_res = 32'h00C0FFEE;
    tick();
    chk("mo_ld_valid", 64'(mem_valid), 64'd1);
    stall_ex = 1; ex_acc = 64'h55; ex_cnt = 2'd1;
    tick();
    chk("mo_s1_acc", acc_fb, 64'h55);
    chk("mo_s1_cnt", 64'(cnt_fb), 64'd1);
    rst = 0; ex_acc = 64'h77; ex_cnt = 2'd2;
    tick();
    chk("mo_rst_acc", acc_fb, 64'd0);
    chk("mo_rst_cnt", 64'(cnt_fb), 64'd0);
    chk_empty("mo_rst");
    rst = 1; stall_ex = 0; ex_alu_res = 32'h0BADF00D; ex_waddr = 5'd12;
    tick();
    chk("mo_resume_valid", 64'(mem_valid), 64'd1);
    chk("mo_resume_alu", 64'(mem_alu_res), 64'h0BADF00D);
    chk("mo_resume_waddr", 64'(mem_waddr), 64'd12);
    chk("mo_resume_acc", acc_fb, 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX/MEM pipeline register for the five-stage core, replacing the fixed 32-bit EX/MEM latch. It adds a stall/bubble/flush control path and a two-way carry path for multi-cycle EX operations (madd/msub, div). Partial accumulator state and step count are held here while EX is stalled, then fed back to EX. It sits between the execute stage and the memory-access stage and is driven by the central stall controller.

## Interface
- DATA_W, 32, GPR/ALU result and HI/LO width
- ADDR_W, 5, register-file address width
- ACC_W, 64, multi-cycle accumulator width (2×DATA_W)
- CNT_W, 2, multi-cycle step counter width
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- stall_ex  in  1  EX stage stalled this cycle
- stall_mem  in  1  MEM stage stalled this cycle
- flush  in  1  discard the EX instruction (exception/branch kill)
- ex_waddr  in  ADDR_W  destination GPR
- ex_reg_we  in  1  GPR write enable
- ex_alu_res  in  DATA_W  ALU result
- ex_hi_we, ex_lo_we  in  1 each  HI/LO write enables
- ex_hi, ex_lo  in  DATA_W each  HI/LO write data
- ex_acc  in  ACC_W  partial accumulator from EX
- ex_cnt  in  CNT_W  current multi-cycle step from EX
- mem_waddr, mem_reg_we, mem_alu_res, mem_hi_we, mem_lo_we, mem_hi, mem_lo  out  as inputs  registered copies to MEM
- mem_valid  out  1  slot holds a real instruction (0 = bubble)
- acc_fb  out  ACC_W  held accumulator returned to EX
- cnt_fb  out  CNT_W  held step count returned to EX

## Operation
- All outputs are registers. There is no combinational input-to-output path.
- Per rising edge, first matching rule wins:
  1. rst==0: all outputs 0 (mem_waddr = NOP address 0, all enables 0, mem_valid 0, acc_fb 0, cnt_fb 0).
  2. flush==1: pipeline outputs cleared as in reset, mem_valid 0. acc_fb and cnt_fb cleared.
  3. stall_ex==1 && stall_mem==0: insert bubble. Pipeline outputs cleared, mem_valid 0. acc_fb←ex_acc, cnt_fb←ex_cnt.
  4. stall_ex==0: load. Every pipeline output takes its ex_* input, mem_valid←1. acc_fb←0, cnt_fb←0.
  5. Otherwise (stall_ex==1 && stall_mem==1): hold all pipeline outputs and mem_valid. acc_fb←ex_acc, cnt_fb←ex_cnt.
- stall_ex==0 && stall_mem==1 is illegal from the controller. Rule 4 applies regardless; the bench asserts it never occurs.
- A bubble never carries a write enable: mem_reg_we, mem_hi_we, mem_lo_we are all 0 whenever mem_valid==0.
- Counter and accumulator are pure storage. No arithmetic is performed here; widths pass through unchanged.

## Timing
- Latency: 1 cycle from ex_* to mem_* on a load edge.
- acc_fb/cnt_fb reflect the EX values captured at the previous stalled edge, and are valid to EX in the following cycle.
- Reset mid multi-cycle op: acc_fb/cnt_fb return to 0 on the same edge, and the op restarts from step 0.
- Flush during a stall: flush wins. The slot empties and feedback clears, even with stall_mem==1.

## Structure
- defines.v gains:
  - RstEnable = 1'b0 and RstDisable = 1'b1
  - Stop/NoStop
  - NOPRegAddr and ZeroWord already there; no new typedefs.
- One sub-module, stage_reg (parameter W, ports clk, rst, clr, hold, d, q), implements reset/clear/hold/load. It is instantiated for the pipeline bundle and for the feedback bundle.
- Top level only decodes the priority rules into clr/hold per bundle.

## Test plan
- Reset: hold rst=0 for 2 cycles with ex_alu_res=0xDEADBEEF, ex_reg_we=1 -> every output 0 after the first edge, mem_valid 0.
- Plain load: rst=1, stalls 0, ex_waddr=5, ex_alu_res=0x12345678, ex_reg_we=1 -> next cycle mem_waddr=5, mem_alu_res=0x12345678, mem_valid=1, acc_fb=0.
- Bubble: stall_ex=1, stall_mem=0, ex_acc=0x1_0000_0002, ex_cnt=1, ex_reg_we=1 -> mem_reg_we=0, mem_valid=0, acc_fb=0x1_0000_0002, cnt_fb=1; releasing the stall with ex_cnt=2 -> load, feedback back to 0.
- Double stall: load 0xAAAA5555, then stall_ex=stall_mem=1 for 3 cycles with changing inputs -> mem_alu_res stays 0xAAAA5555 and acc_fb tracks ex_acc each cycle.
- Flush priority: flush=1 with stall_ex=stall_mem=1 and valid slot -> mem_valid 0, all enables 0, acc_fb 0.
- Mid-op reset: during a 2-cycle madd stall, assert rst=0 for 1 cycle -> acc_fb=0, cnt_fb=0 at that edge, and normal load resumes afterward.
